// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: CPU request/response channel plus the
// word-wide data RAM port.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready is high only while the unit is idle, and
// req_valid seen while req_ready is low is ignored (never queued). The
// response is a single-cycle rsp_valid pulse with no backpressure; rsp_rdata
// and rsp_err are meaningful in that cycle and hold until the next response.
// The RAM reads synchronously: ram_rdata is valid the cycle after ram_addr is
// presented, and it writes the whole word on a clk edge where ram_wen is high.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_wen;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // CPU / RAM side: drives requests and RAM read data
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wdata, ram_wen
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wdata, ram_wen
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide synchronous data RAM. Checks alignment
// and funct3 legality, does read-modify-write for byte/half stores, and
// extracts plus sign/zero-extends load data. One request in flight at a time.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_unit_if.slave     bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    MRG  = 3'd3,
    WR   = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t                state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  ram_wen_q;

  logic                  req_err;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  // Classify the incoming request: misalignment, illegal funct3, or a store
  // using one of the load-only unsigned encodings.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0 and extend it to a full word.
  always_comb begin
    shifted   = bus.ram_rdata >> {addr_q[1:0], 3'b000};
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = bus.ram_rdata;
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  // Replace the targeted byte/half of the word read back in RD.
  always_comb begin
    merged = bus.ram_rdata;
    if (funct3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Control FSM; every handshake/RAM control output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      ram_wen_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      ram_wen_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            funct3_q    <= bus.req_funct3;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              state     <= WR;
              ram_wen_q <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (we_q) begin
            state     <= MRG;
            ram_wen_q <= 1'b1;
          end else begin
            state <= CAP;
          end
        end
        CAP: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= load_data;
        end
        MRG, WR: begin
          state       <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        RESP: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Merged data only exists while the read word is on ram_rdata (MRG).
  assign bus.ram_wdata = (state == MRG) ? merged :
                         (state == WR)  ? wdata_q : '0;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a synchronous-read RAM model.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  logic [2:0] dbg_state;

  mem_access_unit_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  mem_access_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a backdoor preload port
  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_data;
  int          wen_count;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr[11:2]] <= bd_data;
    else if (bus.ram_wen) mem[bus.ram_addr[11:2]] <= bus.ram_wdata;
    if (bus.ram_wen) wen_count <= wen_count + 1;
    bus.ram_rdata <= mem[bus.ram_addr[11:2]];
  end

  // scoreboard
  int checks;
  int errors;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_addr = addr;
    bd_data = data;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err,
                         input logic [31:0] exp_rdata, input int exp_wen);
    int lat;
    int wen0;
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    wen0           = wen_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
    exp_q.push_back(exp_rdata);
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_q.pop_front());
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_wen"}, wen_count - wen0, exp_wen);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wen0;
    checks = 0;
    errors = 0;
    wen_count = 0;
    bd_we = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_err",   {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_wen",   {31'd0, bus.ram_wen}, 32'd0);
    chk("rst_addr",  {20'd0, bus.ram_addr}, 32'd0);
    chk("rst_wdata", bus.ram_wdata, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: word load
    preload(12'h010, 32'hDEADBEEF);
    run_req("lw",  1'b0, 3'b010, 12'h010, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0);

    // 2: byte store via read-modify-write, then byte loads
    preload(12'h020, 32'h11223344);
    run_req("sb",  1'b1, 3'b000, 12'h022, 32'hFFFFFFAB, 3, 1'b0, 32'h0, 1);
    chk("sb_mem", mem[8], 32'h11AB3344);
    run_req("lb",  1'b0, 3'b000, 12'h022, 32'h0, 3, 1'b0, 32'hFFFFFFAB, 0);
    run_req("lbu", 1'b0, 3'b100, 12'h022, 32'h0, 3, 1'b0, 32'h000000AB, 0);
    run_req("lb1", 1'b0, 3'b000, 12'h021, 32'h0, 3, 1'b0, 32'h00000033, 0);
    run_req("lh0", 1'b0, 3'b001, 12'h020, 32'h0, 3, 1'b0, 32'h00003344, 0);

    // 3: upper half store, then half loads
    preload(12'h024, 32'h00000000);
    run_req("sh",  1'b1, 3'b001, 12'h026, 32'h0000BEEF, 3, 1'b0, 32'h0, 1);
    chk("sh_mem", mem[9], 32'hBEEF0000);
    run_req("lh",  1'b0, 3'b001, 12'h026, 32'h0, 3, 1'b0, 32'hFFFFBEEF, 0);
    run_req("lhu", 1'b0, 3'b101, 12'h026, 32'h0, 3, 1'b0, 32'h0000BEEF, 0);

    // 4: errors respond after one cycle, no RAM write, rdata cleared
    run_req("e_lw",  1'b0, 3'b010, 12'h013, 32'h0, 1, 1'b1, 32'h0, 0);
    run_req("e_sh",  1'b1, 3'b001, 12'h021, 32'h1234, 1, 1'b1, 32'h0, 0);
    run_req("e_f3",  1'b0, 3'b011, 12'h020, 32'h0, 1, 1'b1, 32'h0, 0);
    run_req("e_sbu", 1'b1, 3'b100, 12'h020, 32'h77, 1, 1'b1, 32'h0, 0);
    chk("e_mem", mem[8], 32'h11AB3344);

    // 5: word store with req_valid held high throughout
    wen0 = wen_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 12'h030;
    bus.req_wdata  = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("sw_rdy0", {31'd0, bus.req_ready}, 32'd0);
    chk("sw_wen0", {31'd0, bus.ram_wen}, 32'd1);
    @(posedge clk); #1;
    chk("sw_rdy1", {31'd0, bus.req_ready}, 32'd0);
    chk("sw_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("sw_err", {31'd0, bus.rsp_err}, 32'd0);
    @(posedge clk); #1;
    chk("sw_rdy2", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sw_idle", {31'd0, bus.rsp_valid}, 32'd0);
    chk("sw_wens", wen_count - wen0, 1);
    chk("sw_mem", mem[12], 32'hCAFEF00D);

    // 6: reset during the MRG cycle of a byte store
    preload(12'h040, 32'h55555555);
    wen0 = wen_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 12'h040;
    bus.req_wdata  = 32'h000000AA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_state", {29'd0, dbg_state}, 32'd3);
    chk("rmw_wen", {31'd0, bus.ram_wen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rmw_wen_rst", {31'd0, bus.ram_wen}, 32'd0);
    chk("rmw_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rmw_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmw_novalid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rmw_wens", wen_count - wen0, 0);
    chk("rmw_mem", mem[16], 32'h55555555);
    run_req("post_lw", 1'b0, 3'b010, 12'h040, 32'h0, 3, 1'b0, 32'h55555555, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
